// File: rtl/aes_package.sv
// Shared types and helpers for the AES round scheduler.
// Contents: key length enum, scheduler FSM state enum, round-count helper.
// Ports: none (package).
package aes_package;

  localparam int AES_MAX_NR = 14;

  typedef enum logic [1:0] {
    AES_128  = 2'd0,
    AES_192  = 2'd1,
    AES_256  = 2'd2,
    AES_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY_EXP,
    S_WAIT_IN,
    S_ROUND,
    S_WAIT_OUT
  } sched_state_e;

  // Number of cipher rounds for a key length; the reserved code never
  // reaches this because it is rejected at job start.
  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      AES_192: return 4'd12;
      AES_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sched_if.sv
// Block stream handshake between the round scheduler and the in/out streamers.
// Signals: in_valid/in_ready (input block), out_valid/out_ready (result block).
// Modports: master = scheduler side, slave = streamer side.
interface aes_round_sched_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (input in_valid, input out_ready, output in_ready, output out_valid);
  modport slave  (output in_valid, output out_ready, input in_ready, input out_valid);
endinterface

// File: rtl/aes_round_cnt.sv
// Round index counter shared by key expansion and cipher rounds.
// Ports: clk_i/rst_i, clear_i (sync zero), init_i (load 1), step_i (advance),
//        nr_i (terminal count), idx_o (current index), last_o (idx_o == nr_i).
module aes_round_cnt
  import aes_package::*;
#(
  parameter int RND_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [RND_W-1:0] nr_i,
  output logic [RND_W-1:0] idx_o,
  output logic             last_o
);

  assign last_o = (idx_o == nr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_o <= '0;
    end else if (clear_i) begin
      idx_o <= '0;
    end else if (init_i) begin
      idx_o <= RND_W'(1);
    end else if (step_i) begin
      // Wrap on terminal count; the AES_MAX_NR bound keeps a corrupted
      // index from running away past the largest legal round.
      if (last_o || idx_o >= RND_W'(AES_MAX_NR))
        idx_o <= '0;
      else
        idx_o <= idx_o + RND_W'(1);
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// Sequencer for the iterative AES datapath: key expansion, block load, rounds, output handshake.
// Ports: clk_i/rst_i/clear_i, job control (start_i, key_len_i, key_reuse_i, num_blocks_i),
//        stream handshake via strm, datapath strobes, busy_o/done_o/err_o status.
// Optional macro AES_ROUND_SCHED_PERF_EN adds perf_cycles_o / perf_stall_o counters.
module aes_round_sched
  import aes_package::*;
#(
  parameter int BLK_CNT_W = 16,
  parameter int RND_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [1:0]           key_len_i,
  input  logic                 key_reuse_i,
  input  logic [BLK_CNT_W-1:0] num_blocks_i,
  aes_round_sched_if.master    strm,
  output logic                 key_exp_en_o,
  output logic                 load_o,
  output logic                 round_en_o,
  output logic                 final_round_o,
  output logic [RND_W-1:0]     round_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
`ifdef AES_ROUND_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stall_o
`endif
);

  sched_state_e         state;
  key_len_e             job_kl;     // key length of the running job
  key_len_e             key_kl;     // key length the stored schedule was built for
  logic                 key_valid;
  logic [BLK_CNT_W-1:0] blocks_left;
  logic                 done_q;
  logic                 err_q;

  logic [RND_W-1:0]     cnt_idx;
  logic                 cnt_last;

  logic start_ok, start_rsvd, start_zero, reuse_hit, accept, accept_exp;

  assign start_ok   = (state == S_IDLE) && start_i && !clear_i;
  assign start_rsvd = (key_len_i == 2'd3);
  assign start_zero = (num_blocks_i == '0);
  assign reuse_hit  = key_reuse_i && key_valid && (key_kl == key_len_e'(key_len_i));
  assign accept     = start_ok && !start_rsvd && !start_zero;
  assign accept_exp = accept && !reuse_hit;

  aes_round_cnt #(.RND_W(RND_W)) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .init_i  (accept_exp || (state == S_WAIT_IN && strm.in_valid)),
    .step_i  (state == S_KEY_EXP || state == S_ROUND),
    .nr_i    (RND_W'(nr_of(job_kl))),
    .idx_o   (cnt_idx),
    .last_o  (cnt_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      job_kl      <= AES_128;
      key_kl      <= AES_128;
      key_valid   <= 1'b0;
      blocks_left <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (clear_i) begin
        // Abort drops the job and the key schedule, and suppresses done.
        state       <= S_IDLE;
        key_valid   <= 1'b0;
        blocks_left <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              if (start_rsvd) begin
                err_q <= 1'b1;
              end else if (start_zero) begin
                done_q <= 1'b1;
              end else begin
                job_kl      <= key_len_e'(key_len_i);
                blocks_left <= num_blocks_i;
                if (reuse_hit) begin
                  state <= S_WAIT_IN;
                end else begin
                  key_valid <= 1'b0;
                  state     <= S_KEY_EXP;
                end
              end
            end
          end
          S_KEY_EXP: begin
            if (cnt_last) begin
              key_valid <= 1'b1;
              key_kl    <= job_kl;
              state     <= S_WAIT_IN;
            end
          end
          S_WAIT_IN: begin
            if (strm.in_valid) state <= S_ROUND;
          end
          S_ROUND: begin
            if (cnt_last) state <= S_WAIT_OUT;
          end
          S_WAIT_OUT: begin
            if (strm.out_ready) begin
              // <= 1 rather than == 1 so a zero count can never wrap.
              if (blocks_left <= BLK_CNT_W'(1)) begin
                blocks_left <= '0;
                done_q      <= 1'b1;
                state       <= S_IDLE;
              end else begin
                blocks_left <= blocks_left - BLK_CNT_W'(1);
                state       <= S_WAIT_IN;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o        = (state != S_IDLE);
  assign key_exp_en_o  = (state == S_KEY_EXP);
  assign round_en_o    = (state == S_ROUND);
  assign final_round_o = (state == S_ROUND) && cnt_last;
  assign round_idx_o   = (state == S_KEY_EXP || state == S_ROUND) ? cnt_idx : '0;
  assign strm.in_ready  = (state == S_WAIT_IN);
  assign strm.out_valid = (state == S_WAIT_OUT);
  // load is the input handshake itself, so it is qualified by in_valid.
  assign load_o        = (state == S_WAIT_IN) && strm.in_valid;
  assign done_o        = done_q;
  assign err_o         = err_q;

`ifdef AES_ROUND_SCHED_PERF_EN
  logic [31:0] perf_cyc_q, perf_stall_q;
  logic        stall_now;

  assign stall_now = (state == S_WAIT_IN && !strm.in_valid) ||
                     (state == S_WAIT_OUT && !strm.out_ready);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else if (accept) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && !(&perf_cyc_q))      perf_cyc_q   <= perf_cyc_q + 32'd1;
      if (stall_now && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cyc_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: timeline-based reference model,
// directed test-plan jobs with literal expectations, then random traffic.
module tb_aes_round_sched;
  logic        clk = 1'b0;
  logic        rst, clear, start, key_reuse, in_valid, out_ready;
  logic [1:0]  key_len;
  logic [15:0] num_blocks;
  logic        key_exp_en, load, round_en, final_round, busy, done, err;
  logic [3:0]  round_idx;
`ifdef AES_ROUND_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  aes_round_sched_if sif();
  assign sif.in_valid  = in_valid;
  assign sif.out_ready = out_ready;

  aes_round_sched #(.BLK_CNT_W(16), .RND_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .key_len_i(key_len), .key_reuse_i(key_reuse), .num_blocks_i(num_blocks),
    .strm(sif),
    .key_exp_en_o(key_exp_en), .load_o(load), .round_en_o(round_en),
    .final_round_o(final_round), .round_idx_o(round_idx), .busy_o(busy),
    .done_o(done), .err_o(err)
`ifdef AES_ROUND_SCHED_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_stall_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 25)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (time-window based) ----------------
  int mcyc = 0;
  bit m_act, m_kv, m_inflight, m_done_pend, m_err_pend;
  int m_nr, m_blocks, m_kl, m_kl_stored, m_kexp_start, m_rnd_start;
  bit e_busy, e_kexp, e_round, e_final, e_load, e_done, e_err, e_irdy, e_ovld;
  int e_idx;

  task automatic model_reset();
    m_act = 0; m_kv = 0; m_inflight = 0; m_done_pend = 0; m_err_pend = 0;
    m_nr = 10; m_blocks = 0; m_kl = 0; m_kl_stored = 0;
    m_kexp_start = -1000; m_rnd_start = -1000;
  endtask

  task automatic model_eval();
    e_kexp  = m_act && mcyc >= m_kexp_start && mcyc < m_kexp_start + m_nr;
    e_round = m_act && m_inflight && mcyc >= m_rnd_start && mcyc < m_rnd_start + m_nr;
    e_ovld  = m_act && m_inflight && mcyc >= m_rnd_start + m_nr;
    e_irdy  = m_act && !e_kexp && !m_inflight;
    e_idx   = e_kexp ? mcyc - m_kexp_start + 1 : (e_round ? mcyc - m_rnd_start + 1 : 0);
    e_final = e_round && e_idx == m_nr;
    e_load  = e_irdy && in_valid;
    e_busy  = m_act;
    e_done  = m_done_pend;
    e_err   = m_err_pend;
  endtask

  task automatic model_step();
    bit nd, ne;
    nd = 0; ne = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (clear) begin
        m_act = 0; m_kv = 0; m_inflight = 0;
      end else if (!m_act) begin
        if (start) begin
          if (key_len == 2'd3) ne = 1;
          else if (num_blocks == 0) nd = 1;
          else begin
            m_act = 1; m_inflight = 0; m_kl = int'(key_len);
            m_nr = 10 + 2 * m_kl; m_blocks = int'(num_blocks);
            if (key_reuse && m_kv && m_kl_stored == m_kl) m_kexp_start = -1000;
            else begin m_kv = 0; m_kexp_start = mcyc + 1; end
          end
        end
      end else begin
        if (e_kexp && e_idx == m_nr) begin m_kv = 1; m_kl_stored = m_kl; end
        if (e_load) begin m_inflight = 1; m_rnd_start = mcyc + 1; end
        if (e_ovld && out_ready) begin
          m_inflight = 0; m_blocks--;
          if (m_blocks == 0) begin m_act = 0; nd = 1; end
        end
      end
      m_done_pend = nd; m_err_pend = ne;
    end
    mcyc++;
  endtask

  // ---------------- per-job statistics taken from the model ----------------
  int n_kexp, n_round, n_final, n_ohs, n_done, n_err, n_busy, n_ovstall;
  int start_cyc, first_win, hs_cyc, lat, done_at;
  bit prev_ovld;

  task automatic clr_stats();
    n_kexp = 0; n_round = 0; n_final = 0; n_ohs = 0; n_done = 0; n_err = 0;
    n_busy = 0; n_ovstall = 0; first_win = -1; hs_cyc = -1; lat = -1; done_at = -1;
    prev_ovld = 0; start_cyc = mcyc;
  endtask

  // One clock: compare every output at mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk); #1;
    model_eval();
    check("busy",        busy,        e_busy);
    check("key_exp_en",  key_exp_en,  e_kexp);
    check("round_en",    round_en,    e_round);
    check("final_round", final_round, e_final);
    check("round_idx",   round_idx,   e_idx);
    check("load",        load,        e_load);
    check("in_ready",    sif.in_ready,  e_irdy);
    check("out_valid",   sif.out_valid, e_ovld);
    check("done",        done,        e_done);
    check("err",         err,         e_err);
    n_kexp += e_kexp; n_round += e_round; n_final += e_final; n_busy += e_busy;
    n_err += e_err; n_ohs += (e_ovld && out_ready); n_ovstall += (e_ovld && !out_ready);
    if (e_done) begin n_done++; done_at = mcyc - start_cyc; end
    if (e_irdy && first_win < 0) first_win = mcyc - start_cyc;
    if (e_load) hs_cyc = mcyc;
    if (e_ovld && !prev_ovld) lat = mcyc - hs_cyc;
    prev_ovld = e_ovld;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int kl, input bit reuse, input int nb, input int stall_blk);
    bit fin;
    int stall_left;
    fin = 0; stall_left = 5;
    clr_stats();
    start = 1; key_len = 2'(kl); key_reuse = reuse; num_blocks = 16'(nb);
    in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 400; i++) begin
      model_eval();
      if (!m_act && !m_done_pend && !m_err_pend) begin fin = 1; break; end
      out_ready = 1;
      if (e_ovld && n_ohs == stall_blk && stall_left > 0) begin
        out_ready = 0; stall_left--;
      end
      tick();
    end
    if (!fin) check("job_timeout", 1, 0);
  endtask

  initial begin
    rst = 1; clear = 0; start = 0; key_len = 0; key_reuse = 0; num_blocks = 0;
    in_valid = 0; out_ready = 0;
    model_reset();
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick(); tick();
    rst = 0;
    tick();

    // AES-128, one block, streams always ready
    run_job(0, 0, 1, -1);
    check("a128_kexp_cycles", n_kexp, 10);
    check("a128_round_cycles", n_round, 10);
    check("a128_final_count", n_final, 1);
    check("a128_in_to_out_lat", lat, 11);
    check("a128_out_hs", n_ohs, 1);
    check("a128_done_pulses", n_done, 1);

    // AES-256, four blocks, 5-cycle output stall on block 2
    run_job(2, 0, 4, 1);
    check("a256_kexp_cycles", n_kexp, 14);
    check("a256_round_cycles", n_round, 56);
    check("a256_out_hs", n_ohs, 4);
    check("a256_stall_cycles", n_ovstall, 5);
    check("a256_done_pulses", n_done, 1);

    // AES-192 job, then key reuse, then reuse after key_len change
    run_job(1, 0, 1, -1);
    check("a192_kexp_cycles", n_kexp, 12);
    run_job(1, 1, 1, -1);
    check("a192_reuse_kexp", n_kexp, 0);
    check("a192_reuse_wait_in", first_win, 1);
    run_job(0, 1, 1, -1);
    check("reuse_lenchg_kexp", n_kexp, 10);

    // Edge starts
    run_job(0, 0, 0, -1);
    check("nb0_done", n_done, 1);
    check("nb0_done_lat", done_at, 1);
    check("nb0_busy", n_busy, 0);
    run_job(3, 0, 2, -1);
    check("rsvd_err", n_err, 1);
    check("rsvd_done", n_done, 0);
    check("rsvd_busy", n_busy, 0);

    // Asynchronous reset during round 5
    clr_stats();
    start = 1; key_len = 0; key_reuse = 1; num_blocks = 3; in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 60; i++) begin
      model_eval();
      if (e_round && e_idx == 5) break;
      tick();
    end
    check("pre_rst_idx", round_idx, 5);
    rst = 1; #1;
    check("arst_round_en", round_en, 0);
    check("arst_round_idx", round_idx, 0);
    check("arst_busy", busy, 0);
    check("arst_out_valid", sif.out_valid, 0);
    model_reset();
    tick();
    rst = 0;
    tick();
    run_job(0, 1, 1, -1);
    check("post_rst_reuse_kexp", n_kexp, 10);

    // Clear while waiting on the output streamer
    clr_stats();
    start = 1; key_len = 0; key_reuse = 1; num_blocks = 2; in_valid = 1; out_ready = 0;
    tick();
    start = 0;
    for (int i = 0; i < 60; i++) begin
      model_eval();
      if (e_ovld) break;
      tick();
    end
    check("clr_reached_wait_out", sif.out_valid, 1);
    clear = 1; tick(); clear = 0;
    tick(); tick();
    check("clr_no_done", n_done, 0);
    check("clr_idle", busy, 0);
    run_job(0, 1, 1, -1);
    check("post_clr_reuse_kexp", n_kexp, 10);

    // Random traffic: random starts (also while busy), stalls, rare clears
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom % 6) == 0;
      key_len    = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      key_reuse  = 1'($urandom % 2);
      num_blocks = 16'($urandom % 4);
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      clear      = ($urandom % 300) == 0;
      tick();
    end
    clear = 0; start = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
